// File: rtl/otter_pkg.sv
// Shared OTTER core definitions: datapath width, ALU op encodings and the
// multiply/divide unit state type.
package otter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'h00,
        ALU_MUL    = 5'h10,
        ALU_MULH   = 5'h11,
        ALU_MULHSU = 5'h12,
        ALU_MULHU  = 5'h13,
        ALU_DIV    = 5'h14,
        ALU_DIVU   = 5'h15,
        ALU_REM    = 5'h16,
        ALU_REMU   = 5'h17
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } md_state_t;

    function automatic logic is_mop(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Execute-stage hookup of the multiply/divide unit: operands and control from
// the D->E register and hazard unit, stall/done/result back to the pipeline.
interface ex_muldiv_unit_if;
    import otter_pkg::*;

    logic            StartE;
    alu_op_t         ALUControlE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            StallMD;
    logic            DoneMD;
    logic [XLEN-1:0] ResultMD;

    modport master (
        output StartE, ALUControlE, SrcAE, SrcBE, FlushE,
        input  StallMD, DoneMD, ResultMD
    );

    modport slave (
        input  StartE, ALUControlE, SrcAE, SrcBE, FlushE,
        output StallMD, DoneMD, ResultMD
    );

endinterface

// File: rtl/mdu_step_core.sv
// One radix-2 iteration on magnitudes: shift-add for multiply, restoring
// subtract for divide. The accumulator is {hi, lo} = {product hi / remainder, multiplier / quotient}.
module mdu_step_core
    import otter_pkg::*;
(
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    // The partial remainder needs one extra bit after the shift, since it can reach 2*divisor-1.
    always_comb begin
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
        rem_sh = acc_i[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, opnd_i};
        if (!is_div) begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end else if (diff[XLEN]) begin
            acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end else begin
            acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage. Holds the pipeline
// via StallMD for XLEN steps, then presents a sign-corrected result for one cycle.
module ex_muldiv_unit
    import otter_pkg::*;
(
    input logic             CLK,
    input logic             RST_N,
    ex_muldiv_unit_if.slave md
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t         state_q, state_d;
    alu_op_t           op_q, op_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              sgn_a, sgn_b, div_ovf, special;
    logic [XLEN-1:0]   mag_a, mag_b, special_res, final_res;
    logic [2*XLEN-1:0] step_acc, neg_acc;

    assign accept = (state_q == IDLE) && md.StartE && !md.FlushE && is_mop(md.ALUControlE);

    // Divide-by-zero and signed overflow have fixed results and skip the iteration.
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (md.ALUControlE)
            ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM: begin
                sgn_a = md.SrcAE[XLEN-1];
                sgn_b = md.SrcBE[XLEN-1];
            end
            ALU_MULHSU: sgn_a = md.SrcAE[XLEN-1];
            default: ;
        endcase
        mag_a   = sgn_a ? -md.SrcAE : md.SrcAE;
        mag_b   = sgn_b ? -md.SrcBE : md.SrcBE;
        div_ovf = (md.ALUControlE == ALU_DIV || md.ALUControlE == ALU_REM) &&
                  (md.SrcAE == MOST_NEG) && (&md.SrcBE);
        special = md.ALUControlE[2] && ((md.SrcBE == '0) || div_ovf);
        if (md.ALUControlE[1]) begin
            special_res = div_ovf ? '0 : md.SrcAE;
        end else begin
            special_res = div_ovf ? md.SrcAE : '1;
        end
    end

    mdu_step_core u_step (
        .is_div (op_q[2]),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    // Products are negated as a full 2*XLEN value so the high half borrows correctly.
    always_comb begin
        neg_acc = -step_acc;
        case (op_q)
            ALU_MUL:           final_res = neg_q ? neg_acc[XLEN-1:0] : step_acc[XLEN-1:0];
            ALU_DIV, ALU_DIVU: final_res = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
            ALU_REM, ALU_REMU: final_res = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
            default:           final_res = neg_q ? neg_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            op_q     <= ALU_ADD;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (md.FlushE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = special ? DONE : BUSY;
                BUSY:    if (count_q == LAST) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        op_d     = op_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d    = md.ALUControlE;
                count_d = '0;
                acc_d   = {{XLEN{1'b0}}, mag_a};
                opnd_d  = mag_b;
                neg_d   = (md.ALUControlE[2] && md.ALUControlE[1]) ? sgn_a : (sgn_a ^ sgn_b);
                if (special) result_d = special_res;
            end
            BUSY: if (!md.FlushE) begin
                acc_d   = step_acc;
                count_d = count_q + CW'(1);
                if (count_q == LAST) result_d = final_res;
            end
            default: ;
        endcase
    end

    // Stall is suppressed while in reset so no start can appear to be pending.
    always_comb begin
        md.StallMD  = RST_N && (accept || (state_q == BUSY));
        md.DoneMD   = (state_q == DONE) && !md.FlushE;
        md.ResultMD = result_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: expected results go into a scoreboard
// queue at issue time and are popped when DoneMD is seen.
module tb_ex_muldiv_unit;
    import otter_pkg::*;

    logic CLK;
    logic RST_N;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];
    string       mon_tag;
    logic [31:0] mon_exp;

    ex_muldiv_unit_if mdif ();

    ex_muldiv_unit dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .md    (mdif)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cycle <= cycle + 1;

    always @(posedge CLK) begin
        if (RST_N && mdif.StartE)
            assert (is_mop(mdif.ALUControlE)) else $error("[TB] non-M op issued with StartE");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference model written directly from RV32M semantics.
    function automatic logic [31:0] model(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            ALU_MUL:    begin p = ua * ub;           return p[31:0];  end
            ALU_MULH:   begin p = sa * sb;           return p[63:32]; end
            ALU_MULHSU: begin p = sa * $signed(ub);  return p[63:32]; end
            ALU_MULHU:  begin p = ua * ub;           return p[63:32]; end
            ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'h0;
        endcase
    endfunction

    // Scoreboard side: every DoneMD must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RST_N && mdif.DoneMD) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_done", 32'(mdif.DoneMD), 32'h0);
            end else begin
                mon_tag = tag_q.pop_front();
                mon_exp = exp_q.pop_front();
                checkOutput(mon_tag, mdif.ResultMD, mon_exp);
            end
        end
    end

    // Called just after a posedge with the unit idle; checks stall profile and latency.
    task automatic applyStimulus(input string tag, input alu_op_t op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] exp, input int lat,
                                 input bit hold, output int done_at);
        bit seen;
        int stall_bad;
        mdif.StartE      = 1'b1;
        mdif.ALUControlE = op;
        mdif.SrcAE       = a;
        mdif.SrcBE       = b;
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        seen      = 1'b0;
        stall_bad = 0;
        done_at   = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (mdif.StallMD !== (k < lat)) stall_bad++;
            if (mdif.DoneMD) begin
                seen    = 1'b1;
                done_at = cycle;
                checkOutput({tag, "_latency"}, 32'(k), 32'(lat));
                break;
            end
            @(posedge CLK);
            #1;
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 32'h0, 32'h1);
            tag_q.delete();
            exp_q.delete();
        end
        checkOutput({tag, "_stall"}, 32'(stall_bad), 32'h0);
        @(posedge CLK);
        #1;
        if (!hold) mdif.StartE = 1'b0;
    endtask

    alu_op_t     r_op;
    logic [31:0] r_a, r_b;
    int          r_lat, d1, d2;

    initial begin
        RST_N            = 1'b0;
        mdif.StartE      = 1'b0;
        mdif.ALUControlE = ALU_ADD;
        mdif.SrcAE       = '0;
        mdif.SrcBE       = '0;
        mdif.FlushE      = 1'b0;
        #12;
        checkOutput("reset_done",   32'(mdif.DoneMD),  32'h0);
        checkOutput("reset_stall",  32'(mdif.StallMD), 32'h0);
        checkOutput("reset_result", mdif.ResultMD,     32'h0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        applyStimulus("mul_neg",    ALU_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0, d1);
        applyStimulus("mulhu_max",  ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, d1);
        applyStimulus("mulh_m1",    ALU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0, d1);
        applyStimulus("mulhsu",     ALU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b0, d1);
        applyStimulus("div_neg",    ALU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0, d1);
        applyStimulus("rem_neg",    ALU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0, d1);
        applyStimulus("divu",       ALU_DIVU,   32'd100,       32'd7,         32'd14,        33, 1'b0, d1);
        applyStimulus("remu",       ALU_REMU,   32'd100,       32'd7,         32'd2,         33, 1'b0, d1);
        applyStimulus("divu_by0",   ALU_DIVU,   32'h1234,      32'h0,         32'hFFFF_FFFF, 1,  1'b0, d1);
        applyStimulus("rem_by0",    ALU_REM,    32'h1234,      32'h0,         32'h0000_1234, 1,  1'b0, d1);
        applyStimulus("div_ovf",    ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0, d1);
        applyStimulus("rem_ovf",    ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  1'b0, d1);

        for (int i = 0; i < 8; i++) begin
            r_op  = alu_op_t'(5'h10 + 5'($urandom_range(0, 7)));
            r_a   = $urandom;
            r_b   = $urandom;
            r_lat = (r_op[2] && ((r_b == 0) || ((r_op == ALU_DIV || r_op == ALU_REM) &&
                     r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF))) ? 1 : 33;
            applyStimulus($sformatf("rand%0d_op%0h", i, r_op), r_op, r_a, r_b, model(r_op, r_a, r_b),
                          r_lat, 1'b0, d1);
        end

        // A flush in IDLE wins over a simultaneous start.
        mdif.StartE      = 1'b1;
        mdif.FlushE      = 1'b1;
        mdif.ALUControlE = ALU_MUL;
        mdif.SrcAE       = 32'd9;
        mdif.SrcBE       = 32'd9;
        @(negedge CLK);
        checkOutput("flush_idle_stall", 32'(mdif.StallMD), 32'h0);
        @(posedge CLK);
        #1;
        mdif.StartE = 1'b0;
        mdif.FlushE = 1'b0;
        repeat (40) @(negedge CLK);
        checkOutput("flush_idle_no_busy", 32'(mdif.StallMD), 32'h0);
        @(posedge CLK);
        #1;

        // Abort a divide mid-iteration, then run a multiply straight after.
        mdif.StartE      = 1'b1;
        mdif.ALUControlE = ALU_DIV;
        mdif.SrcAE       = 32'd100;
        mdif.SrcBE       = 32'd7;
        repeat (10) begin
            @(posedge CLK);
            #1;
        end
        mdif.FlushE = 1'b1;
        @(negedge CLK);
        checkOutput("flush_busy_stall", 32'(mdif.StallMD), 32'h1);
        checkOutput("flush_busy_done",  32'(mdif.DoneMD),  32'h0);
        @(posedge CLK);
        #1;
        mdif.FlushE = 1'b0;
        mdif.StartE = 1'b0;
        @(negedge CLK);
        checkOutput("flush_after_stall", 32'(mdif.StallMD), 32'h0);
        checkOutput("flush_after_done",  32'(mdif.DoneMD),  32'h0);
        @(posedge CLK);
        #1;
        applyStimulus("mul_after_flush", ALU_MUL, 32'h0001_0003, 32'd5, 32'h0005_000F, 33, 1'b0, d1);

        applyStimulus("b2b_mul", ALU_MUL, 32'd6,   32'd7,         32'd42,        33, 1'b1, d1);
        applyStimulus("b2b_div", ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 1'b0, d2);
        checkOutput("b2b_gap", 32'(d2 - d1), 32'(XLEN + 2));

        // Asynchronous reset between edges while busy.
        mdif.StartE      = 1'b1;
        mdif.ALUControlE = ALU_MUL;
        mdif.SrcAE       = 32'd3;
        mdif.SrcBE       = 32'd5;
        repeat (5) begin
            @(posedge CLK);
            #1;
        end
        #2;
        RST_N = 1'b0;
        #1;
        checkOutput("async_rst_done",   32'(mdif.DoneMD),  32'h0);
        checkOutput("async_rst_stall",  32'(mdif.StallMD), 32'h0);
        checkOutput("async_rst_result", mdif.ResultMD,     32'h0);
        mdif.StartE = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus("mulhu_after_rst", ALU_MULHU, 32'h8000_0000, 32'd4, 32'h0000_0002, 33, 1'b0, d1);

        repeat (3) @(posedge CLK);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
